// File: rtl/apb_arb_pkg.sv
// Shared types and width helpers for the APB requester arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int DEF_NREQ        = 4;
    localparam int DEF_NSLV        = 2;
    localparam int DEF_AW          = 8;
    localparam int DEF_DW          = 8;
    localparam int DEF_TIMEOUT_CYC = 16;

    // Index width that never collapses to zero bits for a single-entry vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_req_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first valid request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic [PW-1:0]   next_ptr
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        next_ptr  = ptr;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = PW'(idx);
                next_ptr       = PW'((idx + 1) % NREQ);
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin bridge from NREQ requesters onto one APB master with NSLV slave selects.
// Define APB_TIMEOUT_EN to abort ACCESS phases that wait longer than TIMEOUT_CYC cycles.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ        = DEF_NREQ,
    parameter int NSLV        = DEF_NSLV,
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic [AW-1:0]      paddr,
    output logic               pwrite,
    output logic [DW-1:0]      pwdata,
    output logic [NSLV-1:0]    psel,
    output logic               penable,
    input  logic [NSLV*DW-1:0] prdata,
    input  logic [NSLV-1:0]    pready,
    input  logic [NSLV-1:0]    pslverr
);

    localparam int PW = idx_w(NREQ);
    localparam int SW = idx_w(NSLV);

    if ((NSLV & (NSLV - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("apb_req_arbiter: NSLV must be a power of two and TIMEOUT_CYC >= 1");
    end

    apb_state_e      state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [SW-1:0]   sel;

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   grant_idx;
    logic [PW-1:0]   next_ptr;

    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;
    logic [NSLV-1:0] psel_nxt;
    logic [NREQ-1:0] owner_oh;

    logic            sel_ready;
    logic            sel_err;
    logic [DW-1:0]   sel_rdata;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .req_valid (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .next_ptr  (next_ptr)
    );

    // Top address bits pick the slave; a single slave always decodes to index 0.
    function automatic logic [SW-1:0] slave_of(input logic [AW-1:0] a);
        if (NSLV > 1) return a[AW-1 -: SW];
        else          return '0;
    endfunction

    assign req_ready = (state == IDLE && !rst) ? grant : '0;

    assign win_addr  = req_addr[grant_idx*AW +: AW];
    assign win_wdata = req_wdata[grant_idx*DW +: DW];

    assign sel_ready = pready[sel];
    assign sel_err   = pslverr[sel];
    assign sel_rdata = prdata[sel*DW +: DW];

    always_comb begin
        psel_nxt                     = '0;
        psel_nxt[slave_of(win_addr)] = 1'b1;
        owner_oh                     = '0;
        owner_oh[owner]              = 1'b1;
    end

`ifdef APB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            sel       <= '0;
            psel      <= '0;
            penable   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tcnt      <= '0;
`endif
        end else begin
            rsp_valid <= '0;
            case (state)
                // accept: latch the winner and present SETUP next cycle
                IDLE: begin
                    if (|req_valid) begin
                        paddr  <= win_addr;
                        pwdata <= win_wdata;
                        pwrite <= req_write[grant_idx];
                        owner  <= grant_idx;
                        sel    <= slave_of(win_addr);
                        psel   <= psel_nxt;
                        ptr    <= next_ptr;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    tcnt    <= '0;
`endif
                end
                // completion: response registered here, rsp_valid visible next cycle
                ACCESS: begin
                    if (sel_ready) begin
                        rsp_valid <= owner_oh;
                        rsp_rdata <= pwrite ? '0 : sel_rdata;
                        rsp_err   <= sel_err;
                        psel      <= '0;
                        penable   <= 1'b0;
                        state     <= IDLE;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                        rsp_valid <= owner_oh;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        psel      <= '0;
                        penable   <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with hand-computed expectations.
module tb_apb_req_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_write, req_ready, rsp_valid;
    logic [31:0] req_addr, req_wdata;
    logic [7:0]  rsp_rdata, paddr, pwdata;
    logic        rsp_err, pwrite, penable;
    logic [1:0]  psel, pready, pslverr;
    logic [15:0] prdata;

    int vec  = 0;
    int errs = 0;

    apb_req_arbiter #(
        .NREQ (4), .NSLV (2), .AW (8), .DW (8), .TIMEOUT_CYC (16)
    ) dut (
        .clk (clk), .rst (rst),
        .req_valid (req_valid), .req_write (req_write),
        .req_addr (req_addr), .req_wdata (req_wdata),
        .req_ready (req_ready), .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata), .rsp_err (rsp_err),
        .paddr (paddr), .pwrite (pwrite), .pwdata (pwdata),
        .psel (psel), .penable (penable),
        .prdata (prdata), .pready (pready), .pslverr (pslverr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
        req_valid[i]        = 1'b1;
        req_write[i]        = w;
        req_addr[i*8 +: 8]  = a;
        req_wdata[i*8 +: 8] = d;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        pready    = 2'b11;
        pslverr   = 2'b00;
        prdata    = '0;

        // reset state; ready must stay low while rst is high
        #3;
        req_valid = 4'b0101;
        #1;
        chk("rst_ready",   req_ready, 4'b0000);
        chk("rst_psel",    psel,      2'b00);
        chk("rst_penable", penable,   1'b0);
        chk("rst_rspv",    rsp_valid, 4'b0000);
        chk("rst_paddr",   paddr,     8'h00);
        chk("rst_rdata",   rsp_rdata, 8'h00);
        chk("rst_err",     rsp_err,   1'b0);
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        tick;

        // single write, zero wait states
        put(0, 1'b1, 8'h12, 8'h5A);
        #1 chk("wr_ready", req_ready, 4'b0001);
        tick;
        req_valid = '0;
        chk("wr_setup_psel",  psel,    2'b01);
        chk("wr_setup_pen",   penable, 1'b0);
        chk("wr_setup_paddr", paddr,   8'h12);
        chk("wr_setup_pwd",   pwdata,  8'h5A);
        chk("wr_setup_pwr",   pwrite,  1'b1);
        chk("wr_setup_rdy",   req_ready, 4'b0000);
        tick;
        chk("wr_access_pen",  penable, 1'b1);
        chk("wr_access_psel", psel,    2'b01);
        tick;
        chk("wr_rspv",  rsp_valid, 4'b0001);
        chk("wr_err",   rsp_err,   1'b0);
        chk("wr_rdata", rsp_rdata, 8'h00);
        chk("wr_rel",   {psel, penable}, 3'b000);
        tick;
        chk("wr_rspv_pulse", rsp_valid, 4'b0000);

        // read from slave1 with three wait states; slave0's ready is ignored
        pready = 2'b01;
        prdata = {8'h11, 8'hEE};
        put(1, 1'b0, 8'h80, 8'h00);
        #1 chk("rd_ready", req_ready, 4'b0010);
        tick;
        req_valid = '0;
        chk("rd_setup_psel",  psel,  2'b10);
        chk("rd_setup_paddr", paddr, 8'h80);
        chk("rd_setup_pwr",   pwrite, 1'b0);
        tick;
        for (int i = 0; i < 3; i++) begin
            chk("rd_wait_bus", {psel, penable, paddr}, {2'b10, 1'b1, 8'h80});
            chk("rd_wait_rspv", rsp_valid, 4'b0000);
            tick;
        end
        pready = 2'b11;
        prdata = {8'hC3, 8'hEE};
        chk("rd_last_access", {psel, penable}, 3'b101);
        tick;
        chk("rd_rspv",  rsp_valid, 4'b0010);
        chk("rd_rdata", rsp_rdata, 8'hC3);
        chk("rd_err",   rsp_err,   1'b0);

        // slave error, then a clean transfer accepted in the response cycle
        pslverr = 2'b01;
        prdata  = {8'h00, 8'h77};
        put(0, 1'b0, 8'h05, 8'h00);
        #1 chk("err_ready", req_ready, 4'b0001);
        tick;
        req_valid = '0;
        tick;
        tick;
        chk("err_rspv",  rsp_valid, 4'b0001);
        chk("err_flag",  rsp_err,   1'b1);
        chk("err_rdata", rsp_rdata, 8'h77);
        pslverr = 2'b00;
        put(3, 1'b1, 8'h40, 8'h99);
        #1 chk("ovl_ready", req_ready, 4'b1000);
        tick;
        req_valid = '0;
        chk("ovl_psel", psel, 2'b01);
        tick;
        tick;
        chk("ovl_rspv", rsp_valid, 4'b1000);
        chk("ovl_err",  rsp_err,   1'b0);

        // fairness with every requester continuously asking
        for (int i = 0; i < 4; i++) put(i, 1'b1, 8'(i), 8'(8'h20 + i));
        #1;
        for (int n = 0; n < 6; n++) begin
            chk("rr_grant", req_ready, 32'(4'b0001 << (n % 4)));
            tick;
            tick;
            tick;
            chk("rr_rspv", rsp_valid, 32'(4'b0001 << (n % 4)));
        end
        req_valid = '0;
        #1 chk("rr_idle_ready", req_ready, 4'b0000);

        // reset during a waited ACCESS drops the transfer
        pready = 2'b00;
        put(1, 1'b0, 8'h80, 8'h00);
        #1 chk("rst_xfer_ready", req_ready, 4'b0010);
        tick;
        req_valid = '0;
        tick;
        chk("rst_xfer_access", {psel, penable}, 3'b101);
        tick;
        rst = 1'b1;
        #1;
        chk("rst_async_bus", {psel, penable}, 3'b000);
        chk("rst_async_rspv", rsp_valid, 4'b0000);
        @(posedge clk);
        #2 rst = 1'b0;
        pready = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rst_no_rsp", rsp_valid, 4'b0000);
        end
        put(2, 1'b1, 8'h81, 8'h44);
        put(0, 1'b0, 8'h01, 8'h00);
        #1 chk("post_rst_first", req_ready, 4'b0001);
        tick;
        req_valid[0] = 1'b0;
        tick;
        tick;
        chk("post_rst_rsp0", rsp_valid, 4'b0001);
        chk("post_rst_second", req_ready, 4'b0100);
        tick;
        req_valid = '0;
        chk("post_rst_psel2", psel, 2'b10);
        tick;
        tick;
        chk("post_rst_rsp2", rsp_valid, 4'b0100);

        // slave0 never becomes ready
        pready = 2'b00;
        prdata = {8'h00, 8'hAB};
        put(0, 1'b0, 8'h00, 8'h00);
        #1 chk("to_ready", req_ready, 4'b0001);
        tick;
        req_valid = '0;
        chk("to_setup", {psel, penable}, 3'b010);
        tick;
`ifdef APB_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            chk("to_wait", {psel, penable, rsp_valid}, {2'b01, 1'b1, 4'b0000});
            tick;
        end
        chk("to_rspv",  rsp_valid, 4'b0001);
        chk("to_err",   rsp_err,   1'b1);
        chk("to_rdata", rsp_rdata, 8'h00);
        chk("to_rel",   {psel, penable}, 3'b000);
`else
        for (int i = 0; i < 100; i++) begin
            chk("hold_bus", {psel, penable, rsp_valid}, {2'b01, 1'b1, 4'b0000});
            tick;
        end
        rst = 1'b1;
        #1 chk("hold_rst_rel", {psel, penable}, 3'b000);
        @(posedge clk);
        #2 rst = 1'b0;
`endif
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
